// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO sitting behind the UART receiver.
// Registered level/threshold flags plus a sticky overflow flag; single clock domain.
module uart_rx_fifo #(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_SIZE-1:0]  w_data,
  input  logic                  rd,
  output logic [DATA_SIZE-1:0]  r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q,  count_d;
  logic          empty_q,  empty_d;
  logic          full_q,   full_d;
  logic          af_q,     af_d;
  logic          ovf_q,    ovf_d;
  logic          do_wr,    do_rd;

  // Accept decisions use the registered flags only, so no rd/wr -> flag comb path.
  always_comb begin
    do_wr    = wr & (~full_q | rd);
    do_rd    = rd & ~empty_q;
    wr_ptr_d = wr_ptr_q + PW'(do_wr);
    rd_ptr_d = rd_ptr_q + PW'(do_rd);
    count_d  = wr_ptr_d - rd_ptr_d;
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
               (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
    af_d     = (count_d >= PW'(AF_LEVEL));
    ovf_d    = ovf_q;
    if (wr && full_q && !rd) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (do_wr && !reset) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= w_data;
    end
  end

  assign r_data      = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign count       = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, hand sequences and a data scoreboard.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH        = 16;
  localparam int unsigned AFL          = 12;
  localparam int unsigned CLKS_PER_BIT = 8;
  localparam int unsigned FRAME_CYCLES = 10 * CLKS_PER_BIT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       rd = 1'b0;
  logic       clr_overflow = 1'b0;
  logic [7:0] r_data;
  logic       empty, full, almost_full, overflow;
  logic [4:0] count;

  uart_rx_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] sb [$];
  logic ovf_m = 1'b0;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       rd;
    logic       clr;
    logic       e_empty;
    logic       e_full;
    logic [4:0] e_count;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, " empty"}, 32'(empty), 32'(sb.size() == 0));
    check({tag, " full"}, 32'(full), 32'(sb.size() == DEPTH));
    check({tag, " count"}, 32'(count), 32'(sb.size()));
    check({tag, " almost_full"}, 32'(almost_full), 32'(sb.size() >= AFL));
    check({tag, " overflow"}, 32'(overflow), 32'(ovf_m));
  endtask

  // One clock: drive at negedge, check head data on pops, update model, check flags.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c,
                      input string tag);
    int sz;
    @(negedge clk);
    wr = w; w_data = d; rd = r; clr_overflow = c;
    sz = sb.size();
    if (r && sz > 0) check({tag, " r_data"}, 32'(r_data), 32'(sb[0]));
    @(posedge clk);
    #1;
    if (w && sz == DEPTH && !r) ovf_m = 1'b1;
    else if (c) ovf_m = 1'b0;
    if (r && sz > 0) void'(sb.pop_front());
    if (w && (sz < DEPTH || r)) sb.push_back(d);
    wr = 1'b0; rd = 1'b0; clr_overflow = 1'b0;
    check_flags(tag);
  endtask

  task automatic do_reset(input int cycles, input logic w);
    @(negedge clk);
    reset = 1'b1; wr = w; w_data = 8'h99; rd = 1'b0; clr_overflow = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0; wr = 1'b0;
    sb.delete();
    ovf_m = 1'b0;
    check_flags("reset");
  endtask

  // Receiver model: idle for one frame time, then a one-cycle done tick with the byte.
  task automatic rx_frame(input logic [7:0] b);
    repeat (FRAME_CYCLES - 1) step(1'b0, 8'h00, 1'b0, 1'b0, "rx_idle");
    step(1'b1, b, 1'b0, 1'b0, "rx_done");
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0};
    vecs[3] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0};
    vecs[4] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0};

    do_reset(2, 1'b0);
    check("T1 empty", 32'(empty), 32'd1);
    check("T1 count", 32'(count), 32'd0);

    for (int i = 0; i < 6; i++) begin
      step(vecs[i].wr, vecs[i].d, vecs[i].rd, vecs[i].clr, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl_empty", i), 32'(empty), 32'(vecs[i].e_empty));
      check($sformatf("vec%0d tbl_full", i), 32'(full), 32'(vecs[i].e_full));
      check($sformatf("vec%0d tbl_count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d tbl_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
      if (i == 0) check("vec0 tbl_rdata", 32'(r_data), 32'h0000_00A5);
    end

    // Fill, check threshold, then half-drain and refill across the pointer wrap.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
      check("T3 af", 32'(almost_full), 32'((i + 1) >= 12));
    end
    check("T3 full", 32'(full), 32'd1);
    check("T3 count", 32'(count), 32'd16);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "pop8");
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "refill");
    check("T3 refull", 32'(full), 32'd1);

    // Overflow set, sticky, clear, full-simultaneous and clear-vs-set priority.
    step(1'b1, 8'hEE, 1'b0, 1'b0, "drop");
    check("T4 ovf", 32'(overflow), 32'd1);
    check("T4 count", 32'(count), 32'd16);
    step(1'b0, 8'h00, 1'b0, 1'b0, "sticky");
    check("T4 sticky", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, "clr");
    check("T4 clr", 32'(overflow), 32'd0);
    step(1'b1, 8'h18, 1'b1, 1'b0, "wrrd_full");
    check("T5 full count", 32'(count), 32'd16);
    check("T5 full ovf", 32'(overflow), 32'd0);
    step(1'b1, 8'hEE, 1'b0, 1'b1, "clr_drop");
    check("T4 set wins", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (i == 0) check("T3 head", 32'(r_data), 32'h0000_0009);
      step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, "underflow");
    check("T5 underflow count", 32'(count), 32'd0);

    // Reset wins over a simultaneous push.
    do_reset(1, 1'b1);
    check("reset wins empty", 32'(empty), 32'd1);

    // Integration: back-to-back receiver frames, then a reset mid-stream.
    rx_frame(8'h55);
    rx_frame(8'h3C);
    rx_frame(8'hFF);
    check("T6 count", 32'(count), 32'd3);
    check("T6 head", 32'(r_data), 32'h0000_0055);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "T6 pop");
    rx_frame(8'h11);
    rx_frame(8'h22);
    do_reset(1, 1'b0);
    check("T6 reset empty", 32'(empty), 32'd1);
    rx_frame(8'h77);
    check("T6 after reset head", 32'(r_data), 32'h0000_0077);
    step(1'b0, 8'h00, 1'b1, 1'b0, "T6 pop77");
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_residue: %0d entries left, 0 required", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
